// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// -----------------
// This pipeline stage sits directly in front of the ALU. It takes decoded
// instructions from the decode/register-read stage and resolves both ALU
// operands, forwarding from the ALU result or from writeback where needed.
// It presents the resolved operands, the opcode and the destination info
// to the ALU.
//
// Storage is two slots:
//   - OUT is the oldest entry and drives the out_* ports.
//   - SKID is the younger entry and is used only under backpressure.
// Because of the skid slot, in_ready comes straight from the state register.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds its payload stable while valid
// is 1 and ready is 0. On the upstream side, flush cancels that cycle's
// transfer.
//
// Ports
//   clk, reset      clock; asynchronous active-low reset
//   flush           synchronous discard of all held instructions
//   in_*            decoded instruction from decode (valid/ready)
//   alu_result      ALU output for the entry currently on out_*
//   wb_*            writeback write port (forwarding source)
//   out_*           resolved operands + destination info (valid/ready)
//   stall_count     saturating count of cycles with out_valid & !out_ready
//   dbg_state       current occupancy state (EMPTY=0, ONE=1, FULL=2)
module alu_operand_stage #(
    parameter int WIDTH  = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_inst_id,
    input  logic [REG_AW-1:0] in_rs_addr,
    input  logic [REG_AW-1:0] in_rt_addr,
    input  logic [WIDTH-1:0]  in_rs_data,
    input  logic [WIDTH-1:0]  in_rt_data,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic              in_use_imm,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic              in_wr_en,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [WIDTH-1:0]  wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_inst_id,
    output logic [WIDTH-1:0]  out_in0,
    output logic [WIDTH-1:0]  out_in1,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_wr_en,
    output logic [15:0]       stall_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic consume;
    logic load_out_from_in;
    logic load_out_from_skid;
    logic load_skid;

    logic [3:0]        skid_inst_id;
    logic [WIDTH-1:0]  skid_in0;
    logic [WIDTH-1:0]  skid_in1;
    logic [REG_AW-1:0] skid_rd_addr;
    logic              skid_wr_en;

    logic [WIDTH-1:0]  cap_in0;
    logic [WIDTH-1:0]  cap_in1;

    // Both handshake flags depend only on the state register.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != FULL);
    assign dbg_state = state;

    assign accept  = in_valid & in_ready & ~flush;
    assign consume = out_valid & out_ready;

    // Forwarding priority is: the entry now in OUT (its result is on
    // alu_result this cycle), then the writeback port, then the register
    // file read.
    function automatic logic [WIDTH-1:0] resolve_src(
        input logic [REG_AW-1:0] src,
        input logic [WIDTH-1:0]  rf_data,
        input logic              fwd_alu_en,
        input logic [REG_AW-1:0] fwd_alu_addr,
        input logic [WIDTH-1:0]  fwd_alu_data,
        input logic              fwd_wb_en,
        input logic [REG_AW-1:0] fwd_wb_addr,
        input logic [WIDTH-1:0]  fwd_wb_data
    );
        logic [WIDTH-1:0] res;
        res = rf_data;
        if (fwd_alu_en && (fwd_alu_addr == src)) begin
            res = fwd_alu_data;
        end else if (fwd_wb_en && (fwd_wb_addr == src)) begin
            res = fwd_wb_data;
        end
        return res;
    endfunction

    // Operands are resolved once, when the entry is captured. Held entries
    // are never resolved again.
    always_comb begin
        cap_in0 = resolve_src(in_rs_addr, in_rs_data,
                              out_valid & out_wr_en, out_rd_addr, alu_result,
                              wb_valid, wb_addr, wb_data);
        if (in_use_imm) begin
            cap_in1 = in_imm;
        end else begin
            cap_in1 = resolve_src(in_rt_addr, in_rt_data,
                                  out_valid & out_wr_en, out_rd_addr, alu_result,
                                  wb_valid, wb_addr, wb_data);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and slot load controls
    always_comb begin
        next_state         = state;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        if (flush) begin
            next_state = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state       = ONE;
                        load_out_from_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_out_from_in = 1'b1;
                    end else if (accept) begin
                        next_state = FULL;
                        load_skid  = 1'b1;
                    end else if (consume) begin
                        next_state = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        next_state         = ONE;
                        load_out_from_skid = 1'b1;
                    end
                end
                default: next_state = EMPTY;
            endcase
        end
    end

    // OUT slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_inst_id <= '0;
            out_in0     <= '0;
            out_in1     <= '0;
            out_rd_addr <= '0;
            out_wr_en   <= 1'b0;
        end else if (load_out_from_in) begin
            out_inst_id <= in_inst_id;
            out_in0     <= cap_in0;
            out_in1     <= cap_in1;
            out_rd_addr <= in_rd_addr;
            out_wr_en   <= in_wr_en;
        end else if (load_out_from_skid) begin
            out_inst_id <= skid_inst_id;
            out_in0     <= skid_in0;
            out_in1     <= skid_in1;
            out_rd_addr <= skid_rd_addr;
            out_wr_en   <= skid_wr_en;
        end
    end

    // SKID slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skid_inst_id <= '0;
            skid_in0     <= '0;
            skid_in1     <= '0;
            skid_rd_addr <= '0;
            skid_wr_en   <= 1'b0;
        end else if (load_skid) begin
            skid_inst_id <= in_inst_id;
            skid_in0     <= cap_in0;
            skid_in1     <= cap_in1;
            skid_rd_addr <= in_rd_addr;
            skid_wr_en   <= in_wr_en;
        end
    end

    // Stall counter. It is cleared only by reset and sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (out_valid && !out_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage
// --------------------
// Self-checking bench for alu_operand_stage.
//   - The clock/reset block drives the design.
//   - Driver tasks put instructions on the in_* port.
//   - The scoreboard keeps an expected queue. An entry is pushed when the
//     stage accepts an instruction, and it is popped and compared when the
//     ALU consumes out_*.
//   - A table of hand-computed vectors covers the forwarding paths.
//   - Hand-written sequences cover backpressure, flush, reset and stall
//     counter saturation.
module tb_alu_operand_stage;

    localparam int W = 41;  // {inst_id, in0, in1, rd_addr, wr_en}

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_inst_id;
    logic [3:0]  in_rs_addr;
    logic [3:0]  in_rt_addr;
    logic [15:0] in_rs_data;
    logic [15:0] in_rt_data;
    logic [15:0] in_imm;
    logic        in_use_imm;
    logic [3:0]  in_rd_addr;
    logic        in_wr_en;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_inst_id;
    logic [15:0] out_in0;
    logic [15:0] out_in1;
    logic [3:0]  out_rd_addr;
    logic        out_wr_en;
    logic [15:0] stall_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_exp;

    typedef struct {
        logic [3:0]  id;
        logic [3:0]  rs;
        logic [15:0] rs_data;
        logic [3:0]  rt;
        logic [15:0] rt_data;
        logic        use_imm;
        logic [15:0] imm;
        logic [3:0]  rd;
        logic        wr_en;
        logic [15:0] alu;
        logic        wb_valid;
        logic [3:0]  wb_addr;
        logic [15:0] wb_data;
        logic [15:0] exp_in0;
        logic [15:0] exp_in1;
    } vec_t;

    vec_t tbl[7];
    vec_t va;
    vec_t vb;
    vec_t vc;
    vec_t vd;

    alu_operand_stage #(.WIDTH(16), .REG_AW(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst_id  (in_inst_id),
        .in_rs_addr  (in_rs_addr),
        .in_rt_addr  (in_rt_addr),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .in_imm      (in_imm),
        .in_use_imm  (in_use_imm),
        .in_rd_addr  (in_rd_addr),
        .in_wr_en    (in_wr_en),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst_id (out_inst_id),
        .out_in0     (out_in0),
        .out_in1     (out_in1),
        .out_rd_addr (out_rd_addr),
        .out_wr_en   (out_wr_en),
        .stall_count (stall_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [3:0] id, input logic [3:0] rs, input logic [15:0] rs_data,
        input logic [3:0] rt, input logic [15:0] rt_data,
        input logic use_imm, input logic [15:0] imm,
        input logic [3:0] rd, input logic wr_en, input logic [15:0] alu,
        input logic wbv, input logic [3:0] wba, input logic [15:0] wbd,
        input logic [15:0] e0, input logic [15:0] e1);
        vec_t v;
        v.id = id; v.rs = rs; v.rs_data = rs_data; v.rt = rt; v.rt_data = rt_data;
        v.use_imm = use_imm; v.imm = imm; v.rd = rd; v.wr_en = wr_en; v.alu = alu;
        v.wb_valid = wbv; v.wb_addr = wba; v.wb_data = wbd;
        v.exp_in0 = e0; v.exp_in1 = e1;
        return v;
    endfunction

    function automatic logic [W-1:0] pack_exp(input vec_t v);
        return {v.id, v.exp_in0, v.exp_in1, v.rd, v.wr_en};
    endfunction

    function automatic logic [W-1:0] pack_out();
        return {out_inst_id, out_in0, out_in1, out_rd_addr, out_wr_en};
    endfunction

    // ---------------- driver tasks ----------------
    // These are called shortly after a rising edge. They set up the
    // instruction, together with the forwarding inputs that apply when it is
    // captured.
    task automatic apply_inst(input vec_t v);
        in_inst_id = v.id;
        in_rs_addr = v.rs;
        in_rs_data = v.rs_data;
        in_rt_addr = v.rt;
        in_rt_data = v.rt_data;
        in_use_imm = v.use_imm;
        in_imm     = v.imm;
        in_rd_addr = v.rd;
        in_wr_en   = v.wr_en;
        alu_result = v.alu;
        wb_valid   = v.wb_valid;
        wb_addr    = v.wb_addr;
        wb_data    = v.wb_data;
        cur_exp    = pack_exp(v);
        in_valid   = 1'b1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        wb_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle_in();
        reset = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick();
    endtask

    // ---------------- scoreboard ----------------
    // This runs on the falling edge. It sees the handshakes that the next
    // rising edge will complete. The pop runs before the push so that a
    // consume and an accept in the same cycle stay in order.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(pack_out()), 64'h0);
                end else begin
                    check("scoreboard_out", 64'(pack_out()), 64'(exp_q.pop_front()));
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst_id = '0; in_rs_addr = '0; in_rt_addr = '0; in_rs_data = '0;
        in_rt_data = '0; in_imm = '0; in_use_imm = 1'b0; in_rd_addr = '0;
        in_wr_en = 1'b0; alu_result = '0; wb_valid = 1'b0; wb_addr = '0;
        wb_data = '0; cur_exp = '0;

        // Forwarding table. Instructions are applied back to back with
        // out_ready = 1, so entry k is captured while entry k-1 sits in OUT.
        //             id    rs    rs_data   rt    rt_data   ui    imm       rd    we    alu       wbv   wba   wbd       exp_in0   exp_in1
        tbl[0] = mk(4'h1, 4'h1, 16'h1111, 4'h2, 16'h2222, 1'b0, 16'h0000, 4'h5, 1'b1, 16'hDEAD, 1'b0, 4'h0, 16'h0000, 16'h1111, 16'h2222);
        tbl[1] = mk(4'h2, 4'h5, 16'hAAAA, 4'h6, 16'h6666, 1'b0, 16'h0000, 4'h7, 1'b1, 16'h0505, 1'b0, 4'h0, 16'h0000, 16'h0505, 16'h6666);
        tbl[2] = mk(4'h3, 4'h7, 16'h1234, 4'h7, 16'h4321, 1'b0, 16'h0000, 4'h8, 1'b0, 16'h0777, 1'b1, 4'h7, 16'h0999, 16'h0777, 16'h0777);
        tbl[3] = mk(4'h4, 4'h8, 16'h3333, 4'h9, 16'h4444, 1'b0, 16'h0000, 4'h8, 1'b1, 16'hBBBB, 1'b1, 4'h8, 16'h0888, 16'h0888, 16'h4444);
        tbl[4] = mk(4'h5, 4'h8, 16'h0001, 4'h8, 16'h0002, 1'b1, 16'h0007, 4'h0, 1'b1, 16'h0F0F, 1'b1, 4'h8, 16'h0C0C, 16'h0F0F, 16'h0007);
        tbl[5] = mk(4'h6, 4'h0, 16'h5555, 4'h0, 16'h6666, 1'b0, 16'h0000, 4'h2, 1'b1, 16'h1357, 1'b0, 4'h0, 16'h0000, 16'h1357, 16'h1357);
        tbl[6] = mk(4'h7, 4'h3, 16'h0101, 4'h4, 16'h0202, 1'b0, 16'h0000, 4'h9, 1'b0, 16'h9999, 1'b1, 4'h4, 16'h0404, 16'h0101, 16'h0404);

        // Reset state, checked while reset is held
        #3;
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_in_ready",    64'(in_ready),    64'd1);
        check("rst_out_in0",     64'(out_in0),     64'd0);
        check("rst_out_in1",     64'(out_in1),     64'd0);
        check("rst_stall_count", 64'(stall_count), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick();

        // Back-to-back stream through the forwarding table
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            apply_inst(tbl[i]);
            tick();
            check("table_in_ready",  64'(in_ready),  64'd1);
            check("table_out_valid", 64'(out_valid), 64'd1);
        end
        idle_in();
        tick();
        check("table_drained_valid", 64'(out_valid),    64'd0);
        check("table_queue_empty",   64'(exp_q.size()), 64'd0);
        check("table_no_stall",      64'(stall_count),  64'd0);

        // ALU forwarding beats writeback for a held OUT entry, on both sources
        reset_dut();
        out_ready = 1'b0;
        va = mk(4'h1, 4'h1, 16'h0010, 4'h2, 16'h0020, 1'b0, 16'h0, 4'h3, 1'b1, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0010, 16'h0020);
        vb = mk(4'h2, 4'h3, 16'h1111, 4'h3, 16'h2222, 1'b0, 16'h0, 4'h4, 1'b1, 16'h0042, 1'b1, 4'h3, 16'h0099, 16'h0042, 16'h0042);
        apply_inst(va); tick();
        apply_inst(vb); tick();
        idle_in();
        out_ready = 1'b1;
        tick(); tick();
        check("fwd_alu_drained", 64'(exp_q.size()), 64'd0);

        // OUT does not write, so writeback forwards; the immediate overrides rt
        out_ready = 1'b0;
        va = mk(4'h3, 4'h1, 16'h0010, 4'h2, 16'h0020, 1'b0, 16'h0, 4'h3, 1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0010, 16'h0020);
        vb = mk(4'h4, 4'h3, 16'h1111, 4'h3, 16'h2222, 1'b1, 16'h0007, 4'h4, 1'b1, 16'h0042, 1'b1, 4'h3, 16'h0099, 16'h0099, 16'h0007);
        apply_inst(va); tick();
        apply_inst(vb); tick();
        idle_in();
        out_ready = 1'b1;
        tick(); tick();
        check("fwd_wb_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: three offered, two held, four stall cycles, then drain.
        // C is captured after B has moved into OUT, so rs=6 forwards alu_result.
        reset_dut();
        out_ready = 1'b0;
        va = mk(4'hA, 4'h1, 16'h00A0, 4'h2, 16'h00A1, 1'b0, 16'h0, 4'h3, 1'b1, 16'h0, 1'b0, 4'h0, 16'h0, 16'h00A0, 16'h00A1);
        vb = mk(4'hB, 4'h4, 16'h00B0, 4'h5, 16'h00B1, 1'b0, 16'h0, 4'h6, 1'b1, 16'h0, 1'b0, 4'h0, 16'h0, 16'h00B0, 16'h00B1);
        vc = mk(4'hC, 4'h6, 16'h00C0, 4'h7, 16'h00C1, 1'b0, 16'h0, 4'h8, 1'b1, 16'h0CCC, 1'b0, 4'h0, 16'h0, 16'h0CCC, 16'h00C1);
        apply_inst(va); tick();
        check("bp_in_ready_one", 64'(in_ready), 64'd1);
        apply_inst(vb); tick();
        check("bp_in_ready_full", 64'(in_ready), 64'd0);
        check("bp_state_full",    64'(dbg_state), 64'd2);
        apply_inst(vc);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_stable",     64'(pack_out()), 64'(pack_exp(va)));
            check("bp_in_ready_held",  64'(in_ready),   64'd0);
        end
        check("bp_stall_count", 64'(stall_count), 64'd4);
        out_ready = 1'b1;
        tick();
        check("bp_in_ready_rise", 64'(in_ready), 64'd1);
        tick();
        idle_in();
        tick();
        check("bp_drained_valid", 64'(out_valid),    64'd0);
        check("bp_queue_empty",   64'(exp_q.size()), 64'd0);
        check("bp_stall_final",   64'(stall_count),  64'd4);

        // Flush while FULL with a new instruction offered
        reset_dut();
        out_ready = 1'b0;
        vd = mk(4'hD, 4'h9, 16'h0D00, 4'h9, 16'h0D01, 1'b0, 16'h0, 4'h1, 1'b1, 16'h0, 1'b0, 4'h0, 16'h0, 16'h0D00, 16'h0D01);
        apply_inst(va); tick();
        apply_inst(vb); tick();
        apply_inst(vd);
        flush = 1'b1;
        tick();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        flush = 1'b0;
        idle_in();
        tick();
        check("flush_not_captured", 64'(out_valid),    64'd0);
        check("flush_queue_empty",  64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a cycle while FULL
        reset_dut();
        out_ready = 1'b0;
        apply_inst(va); tick();
        apply_inst(vb); tick();
        idle_in();
        #3;
        reset = 1'b0;
        #1;
        check("areset_out_valid",   64'(out_valid),   64'd0);
        check("areset_in_ready",    64'(in_ready),    64'd1);
        check("areset_out_in0",     64'(out_in0),     64'd0);
        check("areset_out_in1",     64'(out_in1),     64'd0);
        check("areset_out_id",      64'(out_inst_id), 64'd0);
        check("areset_out_rd",      64'(out_rd_addr), 64'd0);
        check("areset_out_wr_en",   64'(out_wr_en),   64'd0);
        check("areset_stall_count", 64'(stall_count), 64'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        tick();

        // Stall counter saturation
        out_ready = 1'b0;
        apply_inst(va); tick();
        idle_in();
        repeat (65534) @(posedge clk);
        #1;
        check("sat_below_max", 64'(stall_count), 64'hFFFE);
        tick();
        check("sat_at_max", 64'(stall_count), 64'hFFFF);
        repeat (5) tick();
        check("sat_held",       64'(stall_count), 64'hFFFF);
        check("sat_out_stable", 64'(pack_out()),  64'(pack_exp(va)));
        out_ready = 1'b1;
        tick();
        check("sat_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
